// File: rtl/seg7_reader.sv
// Reads a multiplexed, active-low 4-digit seven-segment bus and reconstructs the
// displayed 16-bit hex value once every digit has been seen stable.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:6]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] value,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        busy
);

    typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [6:0]  seg_m, s_seg;
    logic [3:0]  an_m, s_an;
    state_t      state, state_d;
    logic [7:0]  count, count_d;
    logic [10:0] snapshot, snapshot_d;
    logic        capture;
    logic        an_valid, same;
    logic [1:0]  sel;
    logic [3:0]  nibble;
    logic        bad;
    logic [3:0]  mask, mask_d;
    logic [15:0] shadow_val, shadow_val_d;
    logic [3:0]  shadow_err, shadow_err_d;
    logic        frame_done;

    always_comb begin
        an_valid = 1'b1;
        sel      = 2'd0;
        case (s_an)
            4'b1110: sel = 2'd0;
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            4'b0111: sel = 2'd3;
            default: an_valid = 1'b0;
        endcase
    end

    always_comb begin
        nibble = 4'h0;
        bad    = 1'b0;
        case (s_seg)
            7'h01: nibble = 4'h0;
            7'h4F: nibble = 4'h1;
            7'h12: nibble = 4'h2;
            7'h06: nibble = 4'h3;
            7'h4C: nibble = 4'h4;
            7'h24: nibble = 4'h5;
            7'h20: nibble = 4'h6;
            7'h0F: nibble = 4'h7;
            7'h00: nibble = 4'h8;
            7'h0C: nibble = 4'h9;
            7'h08: nibble = 4'hA;
            7'h60: nibble = 4'hB;
            7'h31: nibble = 4'hC;
            7'h42: nibble = 4'hD;
            7'h30: nibble = 4'hE;
            7'h38: nibble = 4'hF;
            default: bad = 1'b1;
        endcase
    end

    // A fresh valid pattern counts as its first stable cycle, so STABLE_CYCLES=1
    // captures on the very edge that loads the snapshot.
    always_comb begin
        state_d    = state;
        count_d    = count;
        snapshot_d = snapshot;
        capture    = 1'b0;
        same       = ({s_seg, s_an} == snapshot);
        case (state)
            WAIT: begin
                if (an_valid) begin
                    state_d    = SETTLE;
                    count_d    = 8'd1;
                    snapshot_d = {s_seg, s_an};
                    if (STABLE == 8'd1) begin
                        capture = 1'b1;
                        state_d = HELD;
                    end
                end
            end
            SETTLE, HELD: begin
                if (!an_valid) begin
                    state_d = WAIT;
                end else if (same) begin
                    if (state == SETTLE) begin
                        count_d = count + 8'd1;
                        if (count + 8'd1 == STABLE) begin
                            capture = 1'b1;
                            state_d = HELD;
                        end
                    end
                end else begin
                    state_d    = SETTLE;
                    count_d    = 8'd1;
                    snapshot_d = {s_seg, s_an};
                    if (STABLE == 8'd1) begin
                        capture = 1'b1;
                        state_d = HELD;
                    end
                end
            end
            default: state_d = WAIT;
        endcase
    end

    always_comb begin
        mask_d       = mask;
        shadow_val_d = shadow_val;
        shadow_err_d = shadow_err;
        frame_done   = 1'b0;
        if (capture) begin
            shadow_val_d[{sel, 2'b00} +: 4] = nibble;
            shadow_err_d[sel]               = bad;
            mask_d[sel]                     = 1'b1;
            if (mask_d == 4'hF) begin
                frame_done = 1'b1;
                mask_d     = 4'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_m       <= '1;
            s_seg       <= '1;
            an_m        <= '1;
            s_an        <= '1;
            count       <= 8'd0;
            snapshot    <= 11'd0;
            mask        <= 4'h0;
            shadow_val  <= 16'h0000;
            shadow_err  <= 4'h0;
            value       <= 16'h0000;
            digit_err   <= 4'h0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            seg_m       <= seg_in;
            s_seg       <= seg_m;
            an_m        <= an_in;
            s_an        <= an_m;
            count       <= count_d;
            snapshot    <= snapshot_d;
            mask        <= mask_d;
            shadow_val  <= shadow_val_d;
            shadow_err  <= shadow_err_d;
            frame_valid <= frame_done;
            busy        <= (mask_d != 4'h0);
            if (frame_done) begin
                value     <= shadow_val_d;
                digit_err <= shadow_err_d;
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed scenarios plus random scans, all compared
// against a run-length/frame model of the multiplexed display.
module tb_seg7_reader;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:6]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        busy;

    always #5 clk = ~clk;

    seg7_reader #(.STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
        .value(value), .digit_err(digit_err), .frame_valid(frame_valid), .busy(busy)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0] pat [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // model: two-stage input pipeline, run length of identical valid samples, digit table
    logic [6:0]  m_s1_seg, m_s2_seg;
    logic [3:0]  m_s1_an, m_s2_an;
    logic [10:0] m_prev;
    bit          m_prev_valid;
    int          m_run;
    logic [3:0]  m_nib [4];
    bit          m_err [4];
    bit          m_have [4];
    logic [15:0] m_value;
    logic [3:0]  m_derr;
    bit          m_fv, m_busy;

    int model_diff, fv_count, fv_adjacent, busy_high;
    bit prev_fv;

    task automatic model_step(input bit r, input logic [6:0] seg, input logic [3:0] an);
        bit          valid;
        logic [10:0] samp;
        int          idx;
        logic [3:0]  n;
        bit          e;
        if (r) begin
            m_s1_seg = '1; m_s2_seg = '1; m_s1_an = '1; m_s2_an = '1;
            m_prev = '0; m_prev_valid = 0; m_run = 0;
            for (int i = 0; i < 4; i++) begin m_nib[i] = 0; m_err[i] = 0; m_have[i] = 0; end
            m_value = 0; m_derr = 0; m_fv = 0; m_busy = 0;
            return;
        end
        valid = ($countones(~m_s2_an) == 1);
        samp  = {m_s2_seg, m_s2_an};
        if (valid) m_run = (m_prev_valid && samp == m_prev) ? m_run + 1 : 1;
        else       m_run = 0;
        m_prev = samp;
        m_prev_valid = valid;
        m_fv = 0;
        if (valid && m_run == STABLE) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (m_s2_an[i] == 1'b0) idx = i;
            n = 0; e = 1;
            for (int k = 0; k < 16; k++) if (pat[k] == m_s2_seg) begin n = 4'(k); e = 0; end
            m_nib[idx] = n; m_err[idx] = e; m_have[idx] = 1;
            if (m_have[0] && m_have[1] && m_have[2] && m_have[3]) begin
                m_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                m_derr  = {m_err[3], m_err[2], m_err[1], m_err[0]};
                m_fv = 1;
                for (int i = 0; i < 4; i++) m_have[i] = 0;
            end
        end
        m_busy = m_have[0] | m_have[1] | m_have[2] | m_have[3];
        m_s2_seg = m_s1_seg; m_s2_an = m_s1_an;
        m_s1_seg = seg;      m_s1_an = an;
    endtask

    task automatic tick(input bit r, input logic [3:0] an, input logic [6:0] seg);
        rst = r; an_in = an; seg_in = seg;
        model_step(r, seg, an);
        @(posedge clk); #1;
        if ({value, digit_err, frame_valid, busy} !== {m_value, m_derr, m_fv, m_busy}) model_diff++;
        if (frame_valid === 1'b1) begin
            fv_count++;
            if (prev_fv) fv_adjacent++;
        end
        prev_fv = frame_valid;
        if (busy === 1'b1) busy_high++;
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        repeat (n) tick(0, an, seg);
    endtask

    task automatic clear_obs();
        model_diff = 0; fv_count = 0; fv_adjacent = 0; busy_high = 0; prev_fv = 0;
    endtask

    task automatic do_reset();
        repeat (2) tick(1, 4'hF, 7'h7F);
    endtask

    task automatic test_reset();
        rst = 1; an_in = 4'h0; seg_in = 7'h00;
        clear_obs();
        do_reset();
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h want 0000", value); end
        checks++; if (digit_err !== 4'h0) begin errors++; $display("FAIL reset_err: got %b want 0000", digit_err); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b want 0", frame_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic_frame();
        clear_obs();
        hold(4'b1110, 7'h24, 8); hold(4'b1101, 7'h4C, 8);
        hold(4'b1011, 7'h06, 8); hold(4'b0111, 7'h12, 8);
        hold(4'b1111, 7'h7F, 4);
        checks++; if (value !== 16'h2345) begin errors++; $display("FAIL basic_value: got %h want 2345", value); end
        checks++; if (digit_err !== 4'h0) begin errors++; $display("FAIL basic_err: got %b want 0000", digit_err); end
        checks++; if (fv_count !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", fv_count); end
        checks++; if (model_diff !== 0) begin errors++; $display("FAIL basic_model: %0d cycles differ, want 0", model_diff); end
    endtask

    task automatic test_glitch();
        clear_obs();
        hold(4'b1110, 7'h24, 8); hold(4'b1101, 7'h4C, 3); hold(4'b1111, 7'h7F, 4);
        hold(4'b1101, 7'h0F, 8); hold(4'b1011, 7'h06, 8); hold(4'b0111, 7'h12, 8);
        hold(4'b1111, 7'h7F, 4);
        checks++; if (value !== 16'h2375) begin errors++; $display("FAIL glitch_value: got %h want 2375", value); end
        checks++; if (fv_count !== 1) begin errors++; $display("FAIL glitch_pulses: got %0d want 1", fv_count); end
        checks++; if (model_diff !== 0) begin errors++; $display("FAIL glitch_model: %0d cycles differ, want 0", model_diff); end
    endtask

    task automatic test_blank_digit();
        clear_obs();
        hold(4'b1110, 7'h01, 8); hold(4'b1101, 7'h4F, 8);
        hold(4'b1011, 7'h7F, 8); hold(4'b0111, 7'h06, 8);
        hold(4'b1111, 7'h7F, 4);
        checks++; if (value !== 16'h3010) begin errors++; $display("FAIL blank_value: got %h want 3010", value); end
        checks++; if (digit_err !== 4'b0100) begin errors++; $display("FAIL blank_err: got %b want 0100", digit_err); end
        checks++; if (fv_count !== 1) begin errors++; $display("FAIL blank_pulses: got %0d want 1", fv_count); end
        checks++; if (model_diff !== 0) begin errors++; $display("FAIL blank_model: %0d cycles differ, want 0", model_diff); end
    endtask

    task automatic test_recapture();
        clear_obs();
        hold(4'b1110, 7'h01, 8); hold(4'b1110, 7'h38, 8);
        hold(4'b1101, 7'h31, 8); hold(4'b1011, 7'h42, 8);
        hold(4'b0111, 7'h30, 5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL recap_busy_before: got %b want 1", busy); end
        tick(0, 4'b0111, 7'h30);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL recap_fv: got %b want 1", frame_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL recap_busy_after: got %b want 0", busy); end
        hold(4'b1111, 7'h7F, 4);
        checks++; if (value !== 16'hEDCF) begin errors++; $display("FAIL recap_value: got %h want edcf", value); end
        checks++; if (busy_high !== 32) begin errors++; $display("FAIL recap_busy_cycles: got %0d want 32", busy_high); end
        checks++; if (model_diff !== 0) begin errors++; $display("FAIL recap_model: %0d cycles differ, want 0", model_diff); end
    endtask

    task automatic test_invalid_an();
        clear_obs();
        hold(4'b1100, 7'h12, 20);
        checks++; if (busy_high !== 0) begin errors++; $display("FAIL invalid_busy: busy high %0d cycles, want 0", busy_high); end
        checks++; if (fv_count !== 0) begin errors++; $display("FAIL invalid_pulses: got %0d want 0", fv_count); end
        checks++; if (model_diff !== 0) begin errors++; $display("FAIL invalid_model: %0d cycles differ, want 0", model_diff); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        clear_obs();
        hold(4'b1110, 7'h24, 8); hold(4'b1101, 7'h4C, 8);
        tick(1, 4'b1101, 7'h4C);
        hold(4'b1011, 7'h06, 8); hold(4'b0111, 7'h12, 8);
        hold(4'b1111, 7'h7F, 4);
        checks++; if (fv_count !== 0) begin errors++; $display("FAIL midrst_pulses: got %0d want 0", fv_count); end
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL midrst_value: got %h want 0000", value); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b want 1", busy); end
        checks++; if (model_diff !== 0) begin errors++; $display("FAIL midrst_model: %0d cycles differ, want 0", model_diff); end
    endtask

    task automatic test_reset_collision();
        do_reset();
        clear_obs();
        hold(4'b1110, 7'h24, 8); hold(4'b1101, 7'h4C, 8); hold(4'b1011, 7'h06, 8);
        hold(4'b0111, 7'h12, 5);
        tick(1, 4'b0111, 7'h12);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL collide_fv: got %b want 0", frame_valid); end
        checks++; if (value !== 16'h0000) begin errors++; $display("FAIL collide_value: got %h want 0000", value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL collide_busy: got %b want 0", busy); end
        hold(4'b1111, 7'h7F, 4);
        checks++; if (fv_count !== 0) begin errors++; $display("FAIL collide_pulses: got %0d want 0", fv_count); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] an;
        do_reset();
        clear_obs();
        for (int f = 0; f < 5; f++)
            for (int d = 0; d < 4; d++) begin
                an = 4'hF;
                an[d] = 1'b0;
                hold(an, pat[$urandom_range(0, 15)], 8);
            end
        hold(4'b1111, 7'h7F, 4);
        checks++; if (fv_count !== 5) begin errors++; $display("FAIL b2b_pulses: got %0d want 5", fv_count); end
        checks++; if (fv_adjacent !== 0) begin errors++; $display("FAIL b2b_adjacent: got %0d want 0", fv_adjacent); end
        checks++; if (model_diff !== 0) begin errors++; $display("FAIL b2b_model: %0d cycles differ, want 0", model_diff); end
    endtask

    task automatic test_random();
        logic [3:0] an;
        logic [6:0] seg;
        int         sel;
        clear_obs();
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7) begin an = 4'hF; an[$urandom_range(0, 3)] = 1'b0; end
            else if (sel < 8) an = 4'hF;
            else an = 4'($urandom);
            seg = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pat[$urandom_range(0, 15)];
            hold(an, seg, $urandom_range(1, 10));
        end
        hold(4'b1111, 7'h7F, 4);
        checks++; if (model_diff !== 0) begin errors++; $display("FAIL random_model: %0d cycles differ, want 0", model_diff); end
        checks++; if (value !== m_value) begin errors++; $display("FAIL random_value: got %h want %h", value, m_value); end
        checks++; if (fv_adjacent !== 0) begin errors++; $display("FAIL random_adjacent: got %0d want 0", fv_adjacent); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_glitch();
        test_blank_digit();
        test_recapture();
        test_invalid_an();
        test_mid_reset();
        test_reset_collision();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, legal 1..255: consecutive identical synchronized samples required before a digit is captured.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 seg_in  input  [0:6]  active-low segment lines; index 0 = a ... index 6 = g, so a is the MSB of the 7-bit value.
REQ-005 an_in  input  [3:0]  active-low digit enables; bit n selects digit n, and digit 0 is the least-significant nibble.
REQ-006 value  output  [15:0]  last complete frame; digit n occupies value[4n+3:4n].
REQ-007 digit_err  output  [3:0]  bit n set if digit n of the last frame was an unrecognized pattern.
REQ-008 frame_valid  output  1  one-cycle pulse marking an update of value and digit_err.
REQ-009 busy  output  1  high while at least one digit of the current frame is captured and the frame is incomplete.

Function
REQ-010 seg_in and an_in SHALL pass through a 2-flop synchronizer; all further logic uses only the synchronized copies (s_seg, s_an).
REQ-011 s_an is valid only when exactly one bit is 0; all-ones, or more than one zero, is invalid.
REQ-012 FSM states: WAIT, SETTLE, HELD.
REQ-013 WAIT -> SETTLE when s_an is valid; count loads 1 and snapshot loads {s_seg, s_an}.
REQ-014 SETTLE: if {s_seg, s_an} equals snapshot, count increments; on a differing valid input, snapshot reloads and count = 1; on an invalid s_an, go to WAIT.
REQ-015 SETTLE: when count reaches STABLE_CYCLES, capture the digit and go to HELD in the same edge.
REQ-016 When STABLE_CYCLES = 1, capture SHALL occur on the edge that enters SETTLE.
REQ-017 HELD: stay while input equals snapshot, with no further capture; on a differing valid input, go to SETTLE with count = 1; on an invalid s_an, go to WAIT.
REQ-018 Decode table, segments a..g as a 7-bit hex value to nibble: 01->0, 4F->1, 12->2, 06->3, 4C->4, 24->5, 20->6, 0F->7, 00->8, 0C->9, 08->A, 60->B, 31->C, 42->D, 30->E, 38->F.
REQ-019 Any other pattern, including 7F (blank), SHALL decode to nibble 0 and set the shadow error bit for that digit.
REQ-020 A capture writes the nibble and error bit into shadow registers for the selected digit and sets that digit's bit in a 4-bit capture mask.
REQ-021 Recapturing a digit already in the mask overwrites its shadow nibble and error bit; the mask is unchanged.
REQ-022 On the capture edge that makes the mask 4'hF:
  - value and digit_err load from the shadow registers, with the current capture included;
  - frame_valid = 1 for exactly that cycle;
  - the mask clears to 0.
REQ-023 value and digit_err SHALL change only on a frame-completing edge and hold between frames.
REQ-024 busy = (mask != 0); it is registered and falls on the frame-completing edge.
REQ-025 Latency: a stable input held from cycle t is captured at edge t + 2 + STABLE_CYCLES - 1, counting the 2 synchronizer stages.
REQ-026 All outputs are registered; there is no combinational input-to-output path.

Reset
REQ-027 While rst = 1, the following SHALL be cleared:
  - state = WAIT;
  - count = 0, snapshot = 0;
  - synchronizer flops = all ones (idle);
  - mask = 0, shadow registers = 0;
  - value = 16'h0000, digit_err = 4'h0, frame_valid = 0, busy = 0.
REQ-028 Reset asserted mid-frame SHALL discard partial captures; no frame_valid follows reset until four new captures.
REQ-029 Reset asserted in the same cycle as a frame-completing capture: reset wins, and frame_valid stays 0.

Verification
REQ-030 STABLE_CYCLES = 4; hold each digit 8 cycles in turn: an=1110 seg=24, an=1101 seg=4C, an=1011 seg=06, an=0111 seg=12 -> single frame_valid pulse, value=16'h2345, digit_err=0.
REQ-031 Same stimulus, but digit 1 held only 3 synchronized cycles then an=1111, later held 8 cycles with seg=0F -> glitch ignored, value=16'h2375.
REQ-032 Digit 2 driven with seg=7F, other digits valid -> value[11:8]=0, digit_err=4'b0100, frame_valid pulses once.
REQ-033 Digit 0 captured with seg=01 then recaptured with seg=38 before the frame completes -> value[3:0]=F; busy=1 from first capture until the frame-completing edge.
REQ-034 an_in=1100 held 20 cycles -> no capture, busy stays 0.
REQ-035 Two digits captured, then rst pulsed for 1 cycle, then two further digits captured -> no frame_valid, value stays 0000.
REQ-036 Continuous 4-digit scan with 8-cycle dwell -> one frame_valid per four captures, never two pulses in consecutive cycles.
